// File: rtl/moore1_pkg.sv
// Shared types and constants for the moore1 serial 1-0-0-1 detector.
package moore1_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 8;
  localparam logic [3:0]  PATTERN = 4'b1001;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_100  = 3'd3,
    S_1001 = 3'd4
  } state_t;

endpackage

// File: rtl/moore1_match_cnt.sv
// Saturating detection counter for moore1; increments on inc, holds at all-ones.
module moore1_match_cnt
  import moore1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/moore1.sv
// Moore FSM detecting serial pattern 1-0-0-1 (oldest bit first), op high in S_1001.
// Optional saturating match counter enabled by macro MOORE1_MATCH_CNT_EN.
module moore1
  import moore1_pkg::*;
#(
  parameter int unsigned OVERLAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ip,
  output logic             op
`ifdef MOORE1_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  state_t state;
  state_t state_n;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and output decode; each state expects the next pattern bit
  always_comb begin
    state_n = S_IDLE;
    op      = 1'b0;
    case (state)
      S_IDLE: state_n = (ip == PATTERN[3]) ? S_1 : S_IDLE;
      S_1:    state_n = (ip == PATTERN[2]) ? S_10 : S_1;
      S_10:   state_n = (ip == PATTERN[1]) ? S_100 : S_1;
      S_100:  state_n = (ip == PATTERN[0]) ? S_1001 : S_IDLE;
      S_1001: begin
        op = 1'b1;
        if (ip) begin
          state_n = S_1;
        end else begin
          state_n = (OVERLAP != 0) ? S_10 : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef MOORE1_MATCH_CNT_EN
  logic inc;

  assign inc = (state_n == S_1001);

  moore1_match_cnt u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .count (match_cnt)
  );
`endif

endmodule

// File: tb/tb_moore1.sv
// Directed self-checking bench for moore1; runs OVERLAP=1 and OVERLAP=0 instances side by side.
module tb_moore1;
  import moore1_pkg::*;

  logic clk;
  logic reset;
  logic ip;
  logic op_ov;
  logic op_no;
  int   errors;
  int   checks;

`ifdef MOORE1_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_ov;
  logic [CNT_W-1:0] cnt_no;
`endif

  moore1 #(.OVERLAP(1)) dut_ov (
    .clk       (clk),
    .reset     (reset),
    .ip        (ip),
    .op        (op_ov)
`ifdef MOORE1_MATCH_CNT_EN
    ,
    .match_cnt (cnt_ov)
`endif
  );

  moore1 #(.OVERLAP(0)) dut_no (
    .clk       (clk),
    .reset     (reset),
    .ip        (ip),
    .op        (op_no)
`ifdef MOORE1_MATCH_CNT_EN
    ,
    .match_cnt (cnt_no)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge with ip=b, then check both op outputs
  task automatic step(input string tag, input logic b, input logic e_ov, input logic e_no);
    ip = b;
    @(posedge clk);
    #1;
    chk_bit({tag, " op_ov"}, op_ov, e_ov);
    chk_bit({tag, " op_no"}, op_no, e_no);
  endtask

  task automatic apply_reset(input string tag, input logic b);
    reset = 1'b1;
    ip    = b;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_bit({tag, " op_ov"}, op_ov, 1'b0);
    chk_bit({tag, " op_no"}, op_no, 1'b0);
`ifdef MOORE1_MATCH_CNT_EN
    chk_cnt({tag, " cnt_ov"}, int'(cnt_ov), 0);
    chk_cnt({tag, " cnt_no"}, int'(cnt_no), 0);
`endif
  endtask

  // Bit vectors are written first-bit-leftmost; element i of n lives at [n-1-i]
  task automatic run_seq(input string tag, input int n, input logic [31:0] bits,
                         input logic [31:0] eov, input logic [31:0] eno);
    for (int i = 0; i < n; i++) begin
      step($sformatf("%s[%0d]", tag, i + 1), bits[n-1-i], eov[n-1-i], eno[n-1-i]);
    end
  endtask

  task automatic chk_counts(input string tag, input int e_ov, input int e_no);
`ifdef MOORE1_MATCH_CNT_EN
    chk_cnt({tag, " cnt_ov"}, int'(cnt_ov), e_ov);
    chk_cnt({tag, " cnt_no"}, int'(cnt_no), e_no);
`else
    if (e_ov < 0 || e_no < 0) $display("negative count expectation in %s", tag);
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    ip     = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    apply_reset("rst", 1'b0);
    checks++;
    assert (dut_ov.state === S_IDLE) else begin
      errors++;
      $error("FAIL rst state observed=%0d expected=%0d", dut_ov.state, S_IDLE);
    end

    // Long overlap sequence: ov pulses after bits 8 and 11, no after bit 8 only
    run_seq("ovl", 21, 32'b100010010011010100011,
                       32'b000000010010000000000,
                       32'b000000010000000000000);
    chk_counts("ovl end", 2, 1);

    // Back-to-back 1001001
    apply_reset("rst2", 1'b1);
    run_seq("b2b", 7, 32'b1001001, 32'b0001001, 32'b0001000);
    chk_counts("b2b end", 2, 1);

    // Near miss
    apply_reset("rst3", 1'b0);
    run_seq("near", 7, 32'b1010001, 32'b0000000, 32'b0000000);
    chk_counts("near end", 0, 0);

    // Reset mid-pattern discards progress
    apply_reset("rst4", 1'b0);
    run_seq("mid", 3, 32'b100, 32'b000, 32'b000);
    apply_reset("mid rst", 1'b1);
    step("mid post", 1'b1, 1'b0, 1'b0);

    // Reset while in S_1001 discards progress
    apply_reset("rst5", 1'b0);
    run_seq("det", 4, 32'b1001, 32'b0001, 32'b0001);
    apply_reset("det rst", 1'b0);
    run_seq("det post", 3, 32'b001, 32'b000, 32'b000);
    chk_counts("det end", 0, 0);

    // Saturation: 1 then 260 x (0,0,1); no instance matches on odd iterations only
    apply_reset("rst6", 1'b0);
    step("sat lead", 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 260; k++) begin
      step($sformatf("sat%0d a", k), 1'b0, 1'b0, 1'b0);
      step($sformatf("sat%0d b", k), 1'b0, 1'b0, 1'b0);
      step($sformatf("sat%0d c", k), 1'b1, 1'b1, 1'((k % 2) == 1));
      if (k == 254 || k == 255 || k == 256 || k == 260) begin
        chk_counts($sformatf("sat%0d", k), (k > 255) ? 255 : k, (k + 1) / 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/moore1.md
MOORE1 -- requirements
Module: moore1

Interface
REQ-001 Parameter OVERLAP, default 1, meaning: 1 = overlapping detection (tail "1" of a match may start the next match); 0 = non-overlapping.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 ip  input  1  serial data bit, one bit sampled per rising clk.
REQ-005 op  output  1  detection flag; high while FSM is in the detect state.
REQ-006 match_cnt  output  8  saturating count of detections; present only when MOORE1_MATCH_CNT_EN is defined.

Function
REQ-007 The block SHALL be a Moore FSM detecting serial pattern 1-0-0-1, oldest bit first.
REQ-008 States SHALL be S_IDLE, S_1, S_10, S_100, S_1001, binary-encoded in 3 bits; the 3 unused codes SHALL transition to S_IDLE on the next edge.
REQ-009 S_IDLE: ip=1 -> S_1; ip=0 -> S_IDLE.
REQ-010 S_1: ip=0 -> S_10; ip=1 -> S_1.
REQ-011 S_10: ip=0 -> S_100; ip=1 -> S_1.
REQ-012 S_100: ip=1 -> S_1001; ip=0 -> S_IDLE.
REQ-013 S_1001 with OVERLAP=1: ip=0 -> S_10, ip=1 -> S_1.
REQ-014 S_1001 with OVERLAP=0: ip=0 -> S_IDLE, ip=1 -> S_1.
REQ-015 op SHALL be decoded from the state register only (op = state==S_1001), never combinationally from ip.
REQ-016 Latency: op SHALL go high for exactly one cycle, starting at the rising edge that samples the final "1" of the pattern.
REQ-017 Back-to-back matches SHALL produce one op pulse per match, separated by at least 2 low cycles (overlap) or 3 low cycles (non-overlap).

Reset
REQ-018 When reset=1 at a rising edge, state SHALL become S_IDLE and op SHALL be 0 after that edge, regardless of ip.
REQ-019 Reset asserted mid-pattern or in S_1001 SHALL discard partial progress; detection restarts from the first edge with reset=0.
REQ-020 match_cnt (when present) SHALL reset to 0.

Configuration
REQ-021 Macro MOORE1_MATCH_CNT_EN: when defined, port match_cnt SHALL exist and increment by 1 on every edge where the next state is S_1001, saturating at 255.
REQ-022 Without MOORE1_MATCH_CNT_EN, port match_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-023 Package moore1_pkg SHALL hold the state typedef (3-bit enum of the five states), the pattern constant 4'b1001 and the counter width constant (8).
REQ-024 The counter SHALL be a sub-module moore1_match_cnt (inputs clk, reset, inc; output count), instantiated only under MOORE1_MATCH_CNT_EN.
REQ-025 The FSM SHALL use one sequential block for the state register and one combinational block for next-state and output decode.

Verification
REQ-026 Reset: reset=1 for one edge with ip=0 -> op=0, state S_IDLE, match_cnt=0.
REQ-027 Overlap: after reset, ip = 1,0,0,0,1,0,0,1,0,0,1,1,0,1,0,1,0,0,0,1,1 (one bit per edge), OVERLAP=1 -> op high exactly after the 8th and 11th bits; match_cnt=2 at end.
REQ-028 Non-overlap: ip = 1,0,0,1,0,0,1 with OVERLAP=0 -> single op pulse after the 4th bit; with OVERLAP=1 -> pulses after the 4th and 7th bits.
REQ-029 Near miss: ip = 1,0,1,0,0,0,1 -> op stays 0 throughout.
REQ-030 Reset mid-pattern: ip = 1,0,0, then reset=1 for one edge with ip=1, then ip=1 -> op stays 0.
REQ-031 Saturation (macro defined): 260 consecutive overlapping matches (ip = 1 then 0,0,1 repeated 260 times) -> match_cnt holds 255, op still pulses once per match.
